// File: rtl/ds_pack.sv
// Data-stop packer: shifts W-bit samples into an N-stage register and presents the packed word.
// Supports shift-left/right, rotate-left, a saturating fill count with full flag, and optional freeze on full.
module ds_pack #(
  parameter int W            = 4,
  parameter int N            = 4,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [1:0]             mode,
  input  logic [W-1:0]           b,
  output logic [W*N-1:0]         d,
  output logic [$clog2(N+1)-1:0] cnt,
  output logic                   full
);

  localparam int            CW      = $clog2(N+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROL  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [W*N-1:0] r_d;
  logic [W*N-1:0] w_d_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_cnt_sat;
  logic           r_full;
  logic           w_frozen;

  assign w_frozen  = (STOP_ON_FULL != 0) && r_full;
  assign w_cnt_sat = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CW'(1));

  // Next-state selection: clear, then data stop / freeze, then the mode operation.
  always_comb begin
    w_d_nxt   = r_d;
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_d_nxt   = '0;
      w_cnt_nxt = '0;
    end else if (!en || w_frozen) begin
      w_d_nxt   = r_d;
      w_cnt_nxt = r_cnt;
    end else begin
      // b is only referenced in the shift branches so it is never sampled while holding.
      case (mode)
        MODE_SHL: begin
          w_d_nxt   = {r_d[W*N-W-1:0], b};
          w_cnt_nxt = w_cnt_sat;
        end
        MODE_SHR: begin
          w_d_nxt   = {b, r_d[W*N-1:W]};
          w_cnt_nxt = w_cnt_sat;
        end
        MODE_ROL: begin
          w_d_nxt   = {r_d[W*N-W-1:0], r_d[W*N-1 -: W]};
          w_cnt_nxt = r_cnt;
        end
        MODE_HOLD: begin
          w_d_nxt   = r_d;
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_d_nxt   = r_d;
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  // State registers; full tracks the count being loaded so it rises on the Nth capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d    <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_d    <= w_d_nxt;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign d    = r_d;
  assign cnt  = r_cnt;
  assign full = r_full;

endmodule

// File: tb/tb_ds_pack.sv
// Self-checking bench for ds_pack: one free-running and one stop-on-full instance share stimulus
// and are compared every edge against a stage-array reference model.
module tb_ds_pack;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           clr;
  logic [1:0]     mode;
  logic [W-1:0]   b;
  logic [W*N-1:0] d0, d1;
  logic [CW-1:0]  cnt0, cnt1;
  logic           full0, full1;

  int total = 0;
  int bad   = 0;

  // Reference state: per instance, an array of stages and a plain fill count.
  logic [W-1:0] st [2][N];
  int           mc [2];

  always #5 clk = ~clk;

  ds_pack #(.W(W), .N(N), .STOP_ON_FULL(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .b(b),
    .d(d0), .cnt(cnt0), .full(full0)
  );

  ds_pack #(.W(W), .N(N), .STOP_ON_FULL(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .b(b),
    .d(d1), .cnt(cnt1), .full(full1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*N-1:0] packed_word(input int k);
    logic [W*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[W*i +: W] = st[k][i];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) st[k][i] = '0;
      mc[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] tmp;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < N; i++) st[k][i] = '0;
        mc[k] = 0;
      end else if (en && !(k == 1 && mc[k] == N)) begin
        if (mode == 2'd0) begin
          for (int i = N-1; i > 0; i--) st[k][i] = st[k][i-1];
          st[k][0] = b;
          if (mc[k] < N) mc[k]++;
        end else if (mode == 2'd1) begin
          for (int i = 0; i < N-1; i++) st[k][i] = st[k][i+1];
          st[k][N-1] = b;
          if (mc[k] < N) mc[k]++;
        end else if (mode == 2'd2) begin
          tmp = st[k][N-1];
          for (int i = N-1; i > 0; i--) st[k][i] = st[k][i-1];
          st[k][0] = tmp;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".d0"},    64'(d0),    64'(packed_word(0)));
    check({tag, ".cnt0"},  64'(cnt0),  64'(mc[0]));
    check({tag, ".full0"}, 64'(full0), 64'(mc[0] == N));
    check({tag, ".d1"},    64'(d1),    64'(packed_word(1)));
    check({tag, ".cnt1"},  64'(cnt1),  64'(mc[1]));
    check({tag, ".full1"}, 64'(full1), 64'(mc[1] == N));
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [W-1:0] bb);
    en = e; clr = c; mode = m; b = bb;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Called 1 time unit after a rising edge: asserts reset well away from any edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    model_clear();
    #1;
    compare_all(tag);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0);
    model_clear();
    #2 reset = 1'b0;
    #1;
    compare_all("async_rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    reset = 1'b1;

    // Shift-left fill and sliding window
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, W'(i));
      tick("shl_fill");
      check("shl_fill.cnt_const", 64'(cnt0), 64'(i));
      check("shl_fill.full_const", 64'(full0), 64'(i == 4));
    end
    check("shl.d_1234", 64'(d0), 64'h1234);
    drive(1'b1, 1'b0, 2'd0, 4'h5);
    tick("shl_slide");
    check("shl.d_2345", 64'(d0), 64'h2345);
    check("shl.frozen_1234", 64'(d1), 64'h1234);

    // Shift-right then rotate
    drive(1'b1, 1'b1, 2'd0, 4'h0);
    tick("clr1");
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 2'd1, W'(i));
      tick("shr_fill");
    end
    check("shr.d_4321", 64'(d0), 64'h4321);
    drive(1'b1, 1'b0, 2'd2, 4'hF);
    tick("rol");
    check("rol.d_3214", 64'(d0), 64'h3214);
    check("rol.cnt", 64'(cnt0), 64'd4);

    // Data stop with X on b must not disturb anything
    drive(1'b1, 1'b1, 2'd0, 4'h0);
    tick("clr2");
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, W'(i));
      tick("ds_fill");
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'd0, (i == 2) ? 4'bxxxx : 4'h9);
      tick("ds_hold");
    end
    check("ds.d_1234", 64'(d0), 64'h1234);
    drive(1'b1, 1'b0, 2'd0, 4'hA);
    tick("ds_resume");
    check("ds.d_234A", 64'(d0), 64'h234A);

    // Stop-on-full freeze and clear
    drive(1'b1, 1'b1, 2'd0, 4'h0);
    tick("clr3");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, W'(4'hB + i));
      tick("sof_fill");
    end
    check("sof.d_BCDE", 64'(d1), 64'hBCDE);
    check("sof.full", 64'(full1), 64'd1);
    drive(1'b1, 1'b0, 2'd0, 4'hF);
    tick("sof_shl");
    drive(1'b1, 1'b0, 2'd2, 4'hF);
    tick("sof_rol");
    check("sof.d_frozen", 64'(d1), 64'hBCDE);
    drive(1'b1, 1'b1, 2'd0, 4'hF);
    tick("sof_clr");
    check("sof.clr_cnt", 64'(cnt1), 64'd0);
    drive(1'b1, 1'b0, 2'd0, 4'hA);
    tick("sof_after");
    check("sof.d_000A", 64'(d1), 64'h000A);

    // Reset mid-fill, then clear colliding with a shift
    drive(1'b1, 1'b1, 2'd0, 4'h0);
    tick("clr4");
    drive(1'b1, 1'b0, 2'd0, 4'h1);
    tick("mid1");
    drive(1'b1, 1'b0, 2'd0, 4'h2);
    tick("mid2");
    check("mid.d_0012", 64'(d0), 64'h0012);
    pulse_reset("mid_rst");
    check("mid_rst.d0", 64'(d0), 64'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 2'd0, W'(i));
      tick("refill");
    end
    check("refill.d_0123", 64'(d0), 64'h0123);
    drive(1'b1, 1'b1, 2'd0, 4'h4);
    tick("clr_coll");
    check("clr_coll.d", 64'(d0), 64'h0);
    check("clr_coll.cnt", 64'(cnt0), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
            2'($urandom_range(0, 3)), W'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset("rand_rst");
        tick("rand_post_rst");
      end else begin
        tick("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
